pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 111 +++++++++++
 tb/tb_pipe_skid_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline-stage register with a valid/ready handshake and a
// 2-entry skid buffer (main entry + skid entry). in_ready is a register bit,
// so downstream backpressure never reaches upstream combinationally.
// Optional feature macro: PIPE_SKID_PERF_EN adds the stall_cnt[31:0] port
// and its saturating stall counter; the datapath is identical either way.
//
// Handshake: a payload moves across an interface only on a cycle where both
// valid and ready are 1 at the rising edge (a "fire"). valid never waits on
// ready. Data is ignored when not firing. While out_valid=1 and out_ready=0,
// out_valid and out_data hold steady until the payload is taken.

module pipe_skid_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   // The state encoding is the pair {skid_v, main_v}; skid_v=1 implies main_v=1,
   // so 2'b10 is unreachable. Probing `state` gives the FSM state directly.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_d;
   logic             main_v;
   logic             skid_v;
   logic             in_fire;
   logic             out_fire;

   // Decode entry valids and the handshake fires from the state register.
   always_comb begin
      main_v    = state[0];
      skid_v    = state[1];
      out_valid = main_v;
      out_data  = main_d;
      in_ready  = ~skid_v;
      occupancy = {1'b0, main_v} + {1'b0, skid_v};
      in_fire   = in_valid & in_ready;
      out_fire  = out_valid & out_ready;
   end

   // Stage FSM: reset beats flush, flush beats any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         main_d <= RST_VAL;
         skid_d <= RST_VAL;
      end else if (flush) begin
         state  <= EMPTY;
         main_d <= RST_VAL;
         skid_d <= RST_VAL;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state  <= ONE;
                  main_d <= in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d <= in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the new payload behind the head.
                  state  <= FULL;
                  skid_d <= in_data;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state  <= ONE;
                  main_d <= skid_d;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef PIPE_SKID_PERF_EN
   // Count cycles where a payload is waiting on downstream; saturates, flush-immune.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus a randomized scoreboard run
// for pipe_skid_reg. With PIPE_SKID_PERF_EN defined, also exercises stall_cnt.

module tb_pipe_skid_reg;

   localparam int          W = 32;
   localparam logic [W-1:0] R = 32'hDEAD_BEEF;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;
`ifdef PIPE_SKID_PERF_EN
   logic [31:0]  stall_cnt;
`endif

   always #5 clk = ~clk;

   pipe_skid_reg #(.WIDTH(W), .RST_VAL(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // ---------------- scoreboard / counters ----------------
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         r;
      logic         f;
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         e_ov;
      logic [W-1:0] e_od;
      logic         e_ir;
      logic [1:0]   e_occ;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // Expected outputs are those seen one edge after the inputs are applied.
      //                 r  f  iv  data  ordy  ov  od    ir  occ
      vecs.push_back('{1'b1,1'b0,1'b0,32'h0, 1'b0, 1'b0,R,     1'b1,2'd0}); // reset
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b0, 1'b0,R,     1'b1,2'd0}); // idle
      vecs.push_back('{1'b0,1'b0,1'b1,32'h11,1'b1, 1'b1,32'h11,1'b1,2'd1}); // stream
      vecs.push_back('{1'b0,1'b0,1'b1,32'h22,1'b1, 1'b1,32'h22,1'b1,2'd1});
      vecs.push_back('{1'b0,1'b0,1'b1,32'h33,1'b1, 1'b1,32'h33,1'b1,2'd1});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b1, 1'b0,32'h33,1'b1,2'd0}); // drained, data kept
      vecs.push_back('{1'b0,1'b0,1'b1,32'hA, 1'b0, 1'b1,32'hA, 1'b1,2'd1}); // skid
      vecs.push_back('{1'b0,1'b0,1'b1,32'hB, 1'b0, 1'b1,32'hA, 1'b0,2'd2});
      vecs.push_back('{1'b0,1'b0,1'b1,32'hD, 1'b0, 1'b1,32'hA, 1'b0,2'd2}); // held, D refused
      vecs.push_back('{1'b0,1'b0,1'b1,32'hD, 1'b1, 1'b1,32'hB, 1'b1,2'd1}); // pop A, D refused
      vecs.push_back('{1'b0,1'b0,1'b1,32'hD, 1'b1, 1'b1,32'hD, 1'b1,2'd1}); // D accepted
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b1, 1'b0,32'hD, 1'b1,2'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,32'hA, 1'b0, 1'b1,32'hA, 1'b1,2'd1}); // fill for flush
      vecs.push_back('{1'b0,1'b0,1'b1,32'hB, 1'b0, 1'b1,32'hA, 1'b0,2'd2});
      vecs.push_back('{1'b0,1'b1,1'b1,32'hC, 1'b0, 1'b0,R,     1'b1,2'd0}); // flush, C dropped
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b0, 1'b0,R,     1'b1,2'd0});
      vecs.push_back('{1'b0,1'b1,1'b1,32'hE, 1'b1, 1'b0,R,     1'b1,2'd0}); // flush beats in_fire
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b1, 1'b0,R,     1'b1,2'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,32'h5, 1'b0, 1'b1,32'h5, 1'b1,2'd1});
      vecs.push_back('{1'b1,1'b0,1'b1,32'h6, 1'b1, 1'b0,R,     1'b1,2'd0}); // rst mid-transfer
      vecs.push_back('{1'b0,1'b0,1'b1,32'h7, 1'b0, 1'b1,32'h7, 1'b1,2'd1});
      vecs.push_back('{1'b0,1'b1,1'b1,32'h8, 1'b1, 1'b0,R,     1'b1,2'd0}); // flush + out_fire
      vecs.push_back('{1'b0,1'b0,1'b1,32'h9, 1'b0, 1'b1,32'h9, 1'b1,2'd1}); // ONE -> FULL
      vecs.push_back('{1'b0,1'b0,1'b1,32'h3C,1'b0, 1'b1,32'h9, 1'b0,2'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b1, 1'b1,32'h3C,1'b1,2'd1});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0, 1'b1, 1'b0,32'h3C,1'b1,2'd0});
   end

   // ---------------- main test ----------------
   initial begin
      logic ir_m, ov_m, ifire, ofire, iv_r, or_r;
      logic [W-1:0] d_r;

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
         tick();
         check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
         check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
         check($sformatf("vec%0d occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
      end

      // Random traffic against a queue model of the stage contents.
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
      exp_q.delete();
      for (int c = 0; c < 10000; c++) begin
         ir_m = (exp_q.size() < 2);
         ov_m = (exp_q.size() > 0);
         check("rnd in_ready", {31'd0, in_ready}, {31'd0, ir_m});
         check("rnd out_valid", {31'd0, out_valid}, {31'd0, ov_m});
         check("rnd occupancy", {30'd0, occupancy}, exp_q.size());
         if (ov_m) check("rnd out_data", out_data, exp_q[0]);
         iv_r = ($urandom_range(0, 3) != 0);
         or_r = ($urandom_range(0, 2) != 0);
         d_r  = $urandom;
         drive(1'b0, 1'b0, iv_r, d_r, or_r);
         ifire = iv_r & ir_m;
         ofire = ov_m & or_r;
         tick();
         if (ofire) void'(exp_q.pop_front());
         if (ifire) exp_q.push_back(d_r);
      end

`ifdef PIPE_SKID_PERF_EN
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
      check("perf reset", stall_cnt, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
      tick();
      check("perf after push", stall_cnt, 32'd0);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      check("perf stall 5", stall_cnt, 32'd5);
      drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      tick();
      check("perf after flush", stall_cnt, 32'd5);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      tick();
      check("perf idle", stall_cnt, 32'd5);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
      check("perf after rst", stall_cnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
